// File: rtl/module_ula_74181_seq_ctrl.sv
// Sequences a W-bit ALU operation through an external 4-bit 74181-style ALU, one nibble per cycle, LSB first.
// Latency: start at edge k -> busy cycles k+1..k+N_NIB, done pulse in cycle k+N_NIB+1.
// Backpressure: none; start is only sampled in IDLE, and requests made while busy are dropped, not queued.
module module_ula_74181_seq_ctrl #(
    parameter int N_NIB = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4*N_NIB-1:0] op_a,
    input  logic [4*N_NIB-1:0] op_b,
    input  logic [3:0]         op_s,
    input  logic               op_m,
    input  logic               op_cin,
    output logic               busy,
    output logic               done,
    output logic [4*N_NIB-1:0] result,
    output logic               c_out,
    output logic               a_eq_b,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [3:0]         alu_s,
    output logic               alu_m,
    output logic               alu_cin,
    output logic               alu_t,
    input  logic [3:0]         alu_f,
    input  logic               alu_cout,
    input  logic               alu_aeqb
);

    localparam int W  = 4 * N_NIB;
    localparam int IW = $clog2(N_NIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [3:0]     s_reg;
    logic           m_reg;
    logic [IW-1:0]  nib_idx;
    logic           carry_reg;
    logic           eq_reg;

    logic           last_nib;
    logic [IW-1:0]  nib_nxt;
    logic           eq_nxt;

    assign last_nib = (nib_idx == IW'(N_NIB - 1));
    assign nib_nxt  = nib_idx + IW'(1);
    assign eq_nxt   = eq_reg & alu_aeqb;

    // Control FSM; alu_* are registered so the nibble for the next RUN cycle is presented one edge ahead.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            m_reg     <= 1'b0;
            nib_idx   <= '0;
            carry_reg <= 1'b0;
            eq_reg    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            c_out     <= 1'b0;
            a_eq_b    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            alu_m     <= 1'b0;
            alu_cin   <= 1'b0;
            alu_t     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        s_reg     <= op_s;
                        m_reg     <= op_m;
                        nib_idx   <= '0;
                        carry_reg <= op_cin;
                        eq_reg    <= 1'b1;
                        busy      <= 1'b1;
                        alu_a     <= op_a[3:0];
                        alu_b     <= op_b[3:0];
                        alu_s     <= op_s;
                        alu_m     <= op_m;
                        alu_cin   <= op_cin;
                        alu_t     <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    result[4*nib_idx +: 4] <= alu_f;
                    carry_reg              <= alu_cout;
                    eq_reg                 <= eq_nxt;
                    if (last_nib) begin
                        // nib_idx parks on the top nibble rather than wrapping.
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        c_out   <= alu_cout;
                        a_eq_b  <= eq_nxt;
                        alu_a   <= '0;
                        alu_b   <= '0;
                        alu_s   <= '0;
                        alu_m   <= 1'b0;
                        alu_cin <= 1'b0;
                        alu_t   <= 1'b0;
                        state   <= DONE;
                    end else begin
                        nib_idx <= nib_nxt;
                        alu_a   <= a_reg[4*nib_nxt +: 4];
                        alu_b   <= b_reg[4*nib_nxt +: 4];
                        alu_s   <= s_reg;
                        alu_m   <= m_reg;
                        alu_cin <= alu_cout;
                        alu_t   <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_ula_74181_seq_ctrl.sv
// Self-checking bench for the nibble-serial ALU sequencer with a behavioural 4-bit ALU in the loop.
// Results are checked through a scoreboard popped on each done pulse; timing checked inline per scenario.
// All waits on the DUT are bounded by cycle budgets.
module tb_module_ula_74181_seq_ctrl;

    localparam int N_NIB = 4;
    localparam int W     = 4 * N_NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   op_s;
    logic         op_m;
    logic         op_cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         a_eq_b;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_cin;
    logic         alu_t;
    logic [3:0]   alu_f;
    logic         alu_cout;
    logic         alu_aeqb;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         eq;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    module_ula_74181_seq_ctrl #(.N_NIB(N_NIB)) dut (
        .clk(clk), .rst(rst), .start(start),
        .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .a_eq_b(a_eq_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
        .alu_cin(alu_cin), .alu_t(alu_t),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_aeqb(alu_aeqb)
    );

    // Behavioural 4-bit ALU: arithmetic S=1001 is A plus B plus carry, logic S=0110 is A xor B.
    always_comb begin
        logic [4:0] sum;
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        alu_f    = 4'h0;
        alu_cout = 1'b0;
        if (alu_m) begin
            if (alu_s == 4'b0110) alu_f = alu_a ^ alu_b;
        end else if (alu_s == 4'b1001) begin
            alu_f    = sum[3:0];
            alu_cout = sum[4];
        end
        alu_aeqb = (alu_a == alu_b);
    end

    function automatic exp_t calc_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [3:0] s, input logic m, input logic cin);
        exp_t         e;
        logic [W:0]   sum;
        sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.eq = (a == b);
        e.res = '0;
        e.c   = 1'b0;
        if (m) begin
            if (s == 4'b0110) e.res = a ^ b;
        end else if (s == 4'b1001) begin
            e.res = sum[W-1:0];
            e.c   = sum[W];
        end
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_done: result=%h with no pending operation", result);
            end else begin
                e = exp_q.pop_front();
                if (result !== e.res || c_out !== e.c || a_eq_b !== e.eq) begin
                    n_bad++;
                    $display("FAIL sb_result: got result=%h c_out=%b a_eq_b=%b, want result=%h c_out=%b a_eq_b=%b",
                             result, c_out, a_eq_b, e.res, e.c, e.eq);
                end
            end
        end
    end

    // Presents one request for a single cycle, then waits (bounded) for done; reports latency and busy cycles.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                         input logic m, input logic cin, output int lat, output int busy_n);
        @(negedge clk);
        op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin; start = 1'b1;
        exp_q.push_back(calc_exp(a, b, s, m, cin));
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_n = 0;
        while (lat <= 20 && !done) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL op_timeout: no done within 20 cycles for a=%h b=%h", a, b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, result, c_out, a_eq_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_status: busy=%b done=%b result=%h c_out=%b a_eq_b=%b, want all 0",
                     busy, done, result, c_out, a_eq_b);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_s, alu_m, alu_cin, alu_t} !== '0) begin
            n_bad++;
            $display("FAIL reset_alu: alu bus=%h, want 0", {alu_a, alu_b, alu_s, alu_m, alu_cin, alu_t});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [W-1:0] a, b;
        logic [W:0]   part;
        int           n, busy_n;
        a = 16'h1234; b = 16'h0FFF;
        @(negedge clk);
        op_a = a; op_b = b; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b0; start = 1'b1;
        exp_q.push_back(calc_exp(a, b, 4'b1001, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        busy_n = 0;
        for (n = 1; n <= 4; n++) begin
            part = {1'b0, a & ((W+1)'(1) << (4*(n-1))) - 1} + {1'b0, b & ((W+1)'(1) << (4*(n-1))) - 1};
            if (busy) busy_n++;
            n_cmp++;
            if (!busy || done || alu_a !== a[4*(n-1) +: 4] || alu_b !== b[4*(n-1) +: 4] ||
                alu_t !== (n > 1) || alu_cin !== part[4*(n-1)] || alu_s !== 4'b1001 || alu_m !== 1'b0) begin
                n_bad++;
                $display("FAIL add_run_cycle%0d: busy=%b done=%b alu_a=%h alu_b=%h alu_t=%b alu_cin=%b, want busy=1 done=0 alu_a=%h alu_b=%h alu_t=%b alu_cin=%b",
                         n, busy, done, alu_a, alu_b, alu_t, alu_cin,
                         a[4*(n-1) +: 4], b[4*(n-1) +: 4], (n > 1), part[4*(n-1)]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || busy_n != 4) begin
            n_bad++;
            $display("FAIL add_latency: cycle5 done=%b busy=%b busy_cycles=%0d, want done=1 busy=0 busy_cycles=4",
                     done, busy, busy_n);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_s, alu_m, alu_cin, alu_t} !== '0) begin
            n_bad++;
            $display("FAIL add_done_alu_idle: alu bus=%h, want 0", {alu_a, alu_b, alu_s, alu_m, alu_cin, alu_t});
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || result !== 16'h2233) begin
            n_bad++;
            $display("FAIL add_hold: done=%b result=%h, want done=0 result=2233", done, result);
        end
    endtask

    task automatic test_carry();
        int lat, busy_n;
        do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, lat, busy_n);
        n_cmp++;
        if (lat != 5) begin
            n_bad++;
            $display("FAIL carry_ripple_latency: %0d, want 5", lat);
        end
        do_op(16'h00FF, 16'h0000, 4'b1001, 1'b0, 1'b1, lat, busy_n);
        n_cmp++;
        if (busy_n != 4) begin
            n_bad++;
            $display("FAIL carry_cin_busy: %0d cycles, want 4", busy_n);
        end
    endtask

    task automatic test_logic();
        int lat, busy_n;
        do_op(16'hA5A5, 16'h0F0F, 4'b0110, 1'b1, 1'b1, lat, busy_n);
        do_op(16'h5A5A, 16'h5A5A, 4'b0110, 1'b1, 1'b0, lat, busy_n);
        do_op(16'h5A5A, 16'h4A5A, 4'b0110, 1'b1, 1'b0, lat, busy_n);
        n_cmp++;
        if (result !== 16'h1000 || a_eq_b !== 1'b0 || c_out !== 1'b0) begin
            n_bad++;
            $display("FAIL logic_neq: result=%h a_eq_b=%b c_out=%b, want 1000 0 0", result, a_eq_b, c_out);
        end
    endtask

    task automatic test_back_to_back();
        int pos[$];
        int base_cnt;
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back(calc_exp(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0));
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 13) start = 1'b0;
            if (done) pos.push_back(n);
        end
        n_cmp++;
        if (pos.size() != 3) begin
            n_bad++;
            $display("FAIL b2b_done_count: %0d done pulses, want 3", pos.size());
        end else begin
            n_cmp++;
            if (pos[0] != 5 || pos[1] != 11 || pos[2] != 17) begin
                n_bad++;
                $display("FAIL b2b_spacing: done at %0d,%0d,%0d, want 5,11,17", pos[0], pos[1], pos[2]);
            end
        end
        // A second request while in RUN must be dropped.
        base_cnt = done_cnt;
        @(negedge clk);
        op_a = 16'h0101; op_b = 16'h0202; start = 1'b1;
        exp_q.push_back(calc_exp(16'h0101, 16'h0202, 4'b1001, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op_a = 16'hFFFF; op_b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        n_cmp++;
        if (done_cnt - base_cnt != 1 || result !== 16'h0303) begin
            n_bad++;
            $display("FAIL start_in_run_ignored: %0d done pulses result=%h, want 1 pulse result=0303",
                     done_cnt - base_cnt, result);
        end
    endtask

    task automatic test_reset_abort();
        int base_cnt;
        base_cnt = done_cnt;
        @(negedge clk);
        op_a = 16'h7777; op_b = 16'h1111; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_bad++;
            $display("FAIL abort_state: busy=%b done=%b result=%h, want 0 0 0000", busy, done, result);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (done_cnt != base_cnt) begin
            n_bad++;
            $display("FAIL abort_no_done: %0d done pulses after abort, want 0", done_cnt - base_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_logic();
        test_back_to_back();
        test_reset_abort();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d expectations never completed, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
